// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one multicycle SHIFT unit between two issue slots.
// Round-robin grant, operand latch, start/done handshake with the SHIFT unit,
// per-requester valid/ready response, flush handling and a done-timeout.
module shift_arbiter #(
    parameter int DW      = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [DW-1:0]    req0_op1_i,
    input  logic [DW-1:0]    req0_op2_i,
    input  logic [DW-1:0]    req0_imm_i,
    input  logic [1:0]       req0_use_part_i,
    input  logic [1:0]       req0_mode1_i,
    input  logic [2:0]       req0_mode2_i,
    input  logic [TAG_W-1:0] req0_tag_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [DW-1:0]    req1_op1_i,
    input  logic [DW-1:0]    req1_op2_i,
    input  logic [DW-1:0]    req1_imm_i,
    input  logic [1:0]       req1_use_part_i,
    input  logic [1:0]       req1_mode1_i,
    input  logic [2:0]       req1_mode2_i,
    input  logic [TAG_W-1:0] req1_tag_i,

    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [DW-1:0]    rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,

    output logic             sh_start_o,
    output logic [DW-1:0]    sh_op1_o,
    output logic [DW-1:0]    sh_op2_o,
    output logic [DW-1:0]    sh_imm_o,
    output logic [1:0]       sh_use_part_o,
    output logic [1:0]       sh_mode1_o,
    output logic [2:0]       sh_mode2_o,
    input  logic             sh_done_i,
    input  logic [DW-1:0]    sh_res_i,

    input  logic             flush_i,
    output logic             busy_o,
    output logic             timeout_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_e;

    state_e           state_q;
    logic             rr_q;
    logic             owner_q;
    logic [DW-1:0]    op1_q;
    logic [DW-1:0]    op2_q;
    logic [DW-1:0]    imm_q;
    logic [1:0]       usePart_q;
    logic [1:0]       mode1_q;
    logic [2:0]       mode2_q;
    logic [TAG_W-1:0] tag_q;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    rspData_q;
    logic             rspErr_q;
    logic             rsp0Valid_q;
    logic             rsp1Valid_q;
    logic             timeoutErr_q;

    logic             grant0;
    logic             grant1;
    logic [CW-1:0]    cnt_d;
    logic             cntExpired;

    assign cnt_d      = cnt_q + CW'(1);
    assign cntExpired = (cnt_q >= CW'(TIMEOUT - 1));

    // Round-robin grant, offered only while idle, out of reset and not flushing
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if ((state_q == IDLE) && rst_ni && !flush_i) begin
            if (req0_valid_i && req1_valid_i) begin
                grant0 = ~rr_q;
                grant1 = rr_q;
            end else begin
                grant0 = req0_valid_i;
                grant1 = req1_valid_i;
            end
        end
    end

    assign req0_ready_o  = grant0;
    assign req1_ready_o  = grant1;
    assign sh_start_o    = (state_q == ISSUE) && !flush_i;
    assign busy_o        = (state_q != IDLE);
    assign rsp0_valid_o  = rsp0Valid_q;
    assign rsp1_valid_o  = rsp1Valid_q;
    assign rsp_data_o    = rspData_q;
    assign rsp_tag_o     = tag_q;
    assign rsp_err_o     = rspErr_q;
    assign timeout_err_o = timeoutErr_q;
    assign sh_op1_o      = op1_q;
    assign sh_op2_o      = op2_q;
    assign sh_imm_o      = imm_q;
    assign sh_use_part_o = usePart_q;
    assign sh_mode1_o    = mode1_q;
    assign sh_mode2_o    = mode2_q;

    // Control FSM: accept, issue, wait for done or timeout, respond, drain after flush
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            owner_q      <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            imm_q        <= '0;
            usePart_q    <= '0;
            mode1_q      <= '0;
            mode2_q      <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            rspData_q    <= '0;
            rspErr_q     <= 1'b0;
            rsp0Valid_q  <= 1'b0;
            rsp1Valid_q  <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant0) begin
                        op1_q     <= req0_op1_i;
                        op2_q     <= req0_op2_i;
                        imm_q     <= req0_imm_i;
                        usePart_q <= req0_use_part_i;
                        mode1_q   <= req0_mode1_i;
                        mode2_q   <= req0_mode2_i;
                        tag_q     <= req0_tag_i;
                        owner_q   <= 1'b0;
                        state_q   <= ISSUE;
                    end else if (grant1) begin
                        op1_q     <= req1_op1_i;
                        op2_q     <= req1_op2_i;
                        imm_q     <= req1_imm_i;
                        usePart_q <= req1_use_part_i;
                        mode1_q   <= req1_mode1_i;
                        mode2_q   <= req1_mode2_i;
                        tag_q     <= req1_tag_i;
                        owner_q   <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= flush_i ? IDLE : WAIT;
                end
                WAIT: begin
                    if (flush_i) begin
                        cnt_q   <= cnt_d;
                        state_q <= sh_done_i ? IDLE : DRAIN;
                    end else if (sh_done_i) begin
                        rspData_q   <= sh_res_i;
                        rspErr_q    <= 1'b0;
                        rsp0Valid_q <= ~owner_q;
                        rsp1Valid_q <= owner_q;
                        state_q     <= RESP;
                    end else if (cntExpired) begin
                        rspData_q    <= '0;
                        rspErr_q     <= 1'b1;
                        timeoutErr_q <= 1'b1;
                        rsp0Valid_q  <= ~owner_q;
                        rsp1Valid_q  <= owner_q;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (flush_i) begin
                        rsp0Valid_q <= 1'b0;
                        rsp1Valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (owner_q ? rsp1_ready_i : rsp0_ready_i) begin
                        rsp0Valid_q <= 1'b0;
                        rsp1Valid_q <= 1'b0;
                        rr_q        <= ~owner_q;
                        state_q     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (sh_done_i) begin
                        state_q <= IDLE;
                    end else if (cntExpired) begin
                        timeoutErr_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
